// File: rtl/reg_file_pkg.sv
// Shared definitions for the mini-RISC16 register file: word/address width macros,
// register count, scoreboard counter width and the counter-update decode helper.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 3
`endif

package reg_file_pkg;

  localparam int WORD_W       = `WORD_WIDTH;
  localparam int ADDR_W       = `REG_ADDR_WIDTH;
  localparam int RF_NUM_REGS  = 2 ** ADDR_W;
  localparam int RF_CNT_WIDTH = 2;

  localparam logic [ADDR_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // An issue and a writeback to the same register in one cycle cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    cnt_op_e op;
    op = CNT_HOLD;
    if (inc && !dec) op = CNT_INC;
    else if (dec && !inc) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters with pending lookup for two read ports and a
// sticky overflow/underflow error flag. RF_BYPASS_EN lets a same-cycle writeback retire.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int CNT_WIDTH = RF_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic              score_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  inc;
  logic [NUM_REGS-1:0]  dec;
  logic [NUM_REGS-1:0]  ovf;
  logic [NUM_REGS-1:0]  unf;
  logic [NUM_REGS-1:0]  pend;

  // Slot 0 never reserves: R0 is hardwired to zero.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = issue_en && (issue_addr == ADDR_W'(r));
      dec[r] = wr_en && (wr_addr == ADDR_W'(r));
    end
  end

  always_comb begin
    ovf = '0;
    unf = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      ovf[r] = (cnt_op(inc[r], dec[r]) == CNT_INC) && (cnt[r] == CNT_MAX);
      unf[r] = (cnt_op(inc[r], dec[r]) == CNT_DEC) && (cnt[r] == '0);
    end
  end

  always_comb begin
    pend = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
`ifdef RF_BYPASS_EN
      pend[r] = (cnt[r] != '0) && !(dec[r] && (cnt[r] == CNT_ONE));
`else
      pend[r] = (cnt[r] != '0);
`endif
    end
  end

  assign pend_a = pend[addr_a];
  assign pend_b = pend[addr_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      score_err <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        case (cnt_op(inc[r], dec[r]))
          CNT_INC: if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
          CNT_DEC: if (cnt[r] != '0)      cnt[r] <= cnt[r] - CNT_ONE;
          default: cnt[r] <= cnt[r];
        endcase
      end
      if ((|ovf) || (|unf)) score_err <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// mini-RISC16 architectural register file: one writeback port, two registered read ports,
// RAW scoreboard. Define RF_BYPASS_EN to forward same-edge writes into the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int CNT_WIDTH = RF_CNT_WIDTH
) (
  input  logic              gclk,
  input  logic              rst,
  input  logic              RegWriteEnable,
  input  logic [ADDR_W-1:0] RegWriteAddr,
  input  logic [WORD_W-1:0] RegWriteData,
  input  logic              ReadEnable,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [WORD_W-1:0] ReadDataA,
  output logic [WORD_W-1:0] ReadDataB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              IssueEnable,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              Stall,
  output logic              ScoreErr
);

  logic [WORD_W-1:0] regs [NUM_REGS];
  logic [WORD_W-1:0] rd_next_a;
  logic [WORD_W-1:0] rd_next_b;
  logic              pend_a;
  logic              pend_b;
  logic              wr_live;

  assign wr_live = RegWriteEnable && (RegWriteAddr != R0);

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_scoreboard (
    .clk        (gclk),
    .rst        (rst),
    .issue_en   (IssueEnable),
    .issue_addr (IssueAddr),
    .wr_en      (RegWriteEnable),
    .wr_addr    (RegWriteAddr),
    .addr_a     (ReadAddrA),
    .addr_b     (ReadAddrB),
    .pend_a     (pend_a),
    .pend_b     (pend_b),
    .score_err  (ScoreErr)
  );

  always_ff @(posedge gclk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_live) begin
      regs[RegWriteAddr] <= RegWriteData;
    end
  end

  // Without forwarding, a same-edge read sees the value held before the write lands.
  always_comb begin
    rd_next_a = regs[ReadAddrA];
    rd_next_b = regs[ReadAddrB];
`ifdef RF_BYPASS_EN
    if (wr_live && (RegWriteAddr == ReadAddrA)) rd_next_a = RegWriteData;
    if (wr_live && (RegWriteAddr == ReadAddrB)) rd_next_b = RegWriteData;
`endif
    if (ReadAddrA == R0) rd_next_a = '0;
    if (ReadAddrB == R0) rd_next_b = '0;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      ReadDataA <= '0;
      ReadDataB <= '0;
      BusyA     <= 1'b0;
      BusyB     <= 1'b0;
    end else if (ReadEnable) begin
      ReadDataA <= rd_next_a;
      ReadDataB <= rd_next_b;
      BusyA     <= pend_a;
      BusyB     <= pend_b;
    end
  end

  assign Stall = ReadEnable && (pend_a || pend_b);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file with a reference model and an expected-read queue.
// Build with RF_BYPASS_EN defined to check the forwarding variant.
module tb_reg_file;
  import reg_file_pkg::*;

  localparam int W       = 2 + 2 * WORD_W;
  localparam int NREG    = RF_NUM_REGS;
  localparam int CNT_TOP = (1 << RF_CNT_WIDTH) - 1;

  logic              gclk = 1'b0;
  logic              rst;
  logic              RegWriteEnable;
  logic [ADDR_W-1:0] RegWriteAddr;
  logic [WORD_W-1:0] RegWriteData;
  logic              ReadEnable;
  logic [ADDR_W-1:0] ReadAddrA;
  logic [ADDR_W-1:0] ReadAddrB;
  logic [WORD_W-1:0] ReadDataA;
  logic [WORD_W-1:0] ReadDataB;
  logic              BusyA;
  logic              BusyB;
  logic              IssueEnable;
  logic [ADDR_W-1:0] IssueAddr;
  logic              Stall;
  logic              ScoreErr;

  always #5 gclk = ~gclk;

  reg_file dut (
    .gclk           (gclk),
    .rst            (rst),
    .RegWriteEnable (RegWriteEnable),
    .RegWriteAddr   (RegWriteAddr),
    .RegWriteData   (RegWriteData),
    .ReadEnable     (ReadEnable),
    .ReadAddrA      (ReadAddrA),
    .ReadAddrB      (ReadAddrB),
    .ReadDataA      (ReadDataA),
    .ReadDataB      (ReadDataB),
    .BusyA          (BusyA),
    .BusyB          (BusyB),
    .IssueEnable    (IssueEnable),
    .IssueAddr      (IssueAddr),
    .Stall          (Stall),
    .ScoreErr       (ScoreErr)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      last_exp;
  logic [WORD_W-1:0] m_regs [NREG];
  int                m_cnt  [NREG];
  logic              m_err;
  logic              exp_stall;
  logic              obs_stall;

  function automatic logic m_pend(input int r, input logic we, input int wa);
    if (r == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (we && wa == r && m_cnt[r] == 1) return 1'b0;
`endif
    return m_cnt[r] != 0;
  endfunction

  function automatic logic [WORD_W-1:0] m_read(input int ra, input logic we, input int wa,
                                               input logic [WORD_W-1:0] wd);
    if (ra == 0) return '0;
`ifdef RF_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m_regs[ra];
  endfunction

  // One clock: drive inputs, record pre-edge Stall, queue the expected read, advance model.
  task automatic step(input logic we, input int wa, input logic [WORD_W-1:0] wd,
                      input logic re, input int ra, input int rb,
                      input logic ie, input int ia);
    RegWriteEnable = we;
    RegWriteAddr   = wa[ADDR_W-1:0];
    RegWriteData   = wd;
    ReadEnable     = re;
    ReadAddrA      = ra[ADDR_W-1:0];
    ReadAddrB      = rb[ADDR_W-1:0];
    IssueEnable    = ie;
    IssueAddr      = ia[ADDR_W-1:0];
    #1;
    obs_stall = Stall;
    exp_stall = re && (m_pend(ra, we, wa) || m_pend(rb, we, wa));
    if (re) exp_q.push_back({m_pend(ra, we, wa), m_pend(rb, we, wa),
                             m_read(ra, we, wa, wd), m_read(rb, we, wa, wd)});
    @(posedge gclk);
    for (int r = 1; r < NREG; r++) begin
      if ((ie && ia == r) && !(we && wa == r)) begin
        if (m_cnt[r] == CNT_TOP) m_err = 1'b1;
        else m_cnt[r]++;
      end else if ((we && wa == r) && !(ie && ia == r)) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r]--;
      end
    end
    if (we && wa != 0) m_regs[wa] = wd;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Next expected read result; the read ports hold it until the next ReadEnable.
  task automatic pop_exp(output logic [W-1:0] e);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue_empty: got 0 entries expected at least 1");
      e = last_exp;
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
    end
  endtask

  // Reset while write, issue and read are all requested: reset must win.
  task automatic do_reset();
    rst = 1'b1;
    RegWriteEnable = 1'b1; RegWriteAddr = 3'd7; RegWriteData = 16'hFFFF;
    ReadEnable = 1'b1; ReadAddrA = 3'd3; ReadAddrB = 3'd7;
    IssueEnable = 1'b1; IssueAddr = 3'd7;
    @(posedge gclk);
    #1;
    rst = 1'b0;
    RegWriteEnable = 1'b0; ReadEnable = 1'b0; IssueEnable = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
    exp_q.delete();
    last_exp = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    do_reset();
    #1;
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== {W{1'b0}} || ScoreErr !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b%b a=%h b=%h err=%b stall=%b expected all 0",
               BusyA, BusyB, ReadDataA, ReadDataB, ScoreErr, Stall);
    end
    for (int r = 1; r < NREG; r++) begin
      step(1'b0, 0, '0, 1'b1, r, NREG - r, 1'b0, 0);
      pop_exp(e);
      checks++;
      if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || e !== {W{1'b0}}) begin
        errors++;
        $display("FAIL reset_read_r%0d: got %h expected %h", r, {BusyA, BusyB, ReadDataA, ReadDataB}, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [W-1:0] e;
    step(1'b1, 3, 16'hBEEF, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 3, 0, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || ReadDataA !== 16'hBEEF || ReadDataB !== 16'h0000) begin
      errors++;
      $display("FAIL write_read_r3: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
    step(1'b1, 0, 16'h1234, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 0, 3, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || ReadDataA !== 16'h0000) begin
      errors++;
      $display("FAIL write_r0_dropped: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] e;
    logic [WORD_W-1:0] lit;
    step(1'b1, 5, 16'h0011, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 5, 16'h00AA, 1'b1, 5, 3, 1'b0, 0);
    pop_exp(e);
`ifdef RF_BYPASS_EN
    lit = 16'h00AA;
`else
    lit = 16'h0011;
`endif
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || ReadDataA !== lit) begin
      errors++;
      $display("FAIL same_edge_read: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
    step(1'b1, 6, 16'h7777, 1'b0, 6, 6, 1'b0, 0);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== last_exp) begin
      errors++;
      $display("FAIL read_hold: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, last_exp);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    step(1'b0, 0, '0, 1'b0, 0, 0, 1'b1, 2);
    step(1'b0, 0, '0, 1'b1, 2, 0, 1'b0, 0);
    checks++;
    if (obs_stall !== exp_stall || obs_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_raw: got %b expected %b", obs_stall, exp_stall);
    end
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || BusyA !== 1'b1) begin
      errors++;
      $display("FAIL busy_raw: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
    step(1'b1, 2, 16'h2222, 1'b1, 2, 0, 1'b0, 0);
    checks++;
    if (obs_stall !== exp_stall) begin
      errors++;
      $display("FAIL stall_on_writeback: got %b expected %b", obs_stall, exp_stall);
    end
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e) begin
      errors++;
      $display("FAIL read_on_writeback: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
    step(1'b0, 0, '0, 1'b1, 2, 2, 1'b0, 0);
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_cleared: got %b expected 0", obs_stall);
    end
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || ReadDataA !== 16'h2222) begin
      errors++;
      $display("FAIL read_after_writeback: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 1'b0, 0, 0, 1'b1, 4);
    checks++;
    if (ScoreErr !== m_err || ScoreErr !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: got %b expected %b", ScoreErr, m_err);
    end
    step(1'b1, 6, 16'h0606, 1'b1, 4, 6, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || ScoreErr !== 1'b1) begin
      errors++;
      $display("FAIL overflow_read: got %h err=%b expected %h err=1",
               {BusyA, BusyB, ReadDataA, ReadDataB}, ScoreErr, e);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 4, 16'h4444, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 4, 0, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || BusyA !== 1'b0) begin
      errors++;
      $display("FAIL saturated_drain: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
    do_reset();
    checks++;
    if (ScoreErr !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_rst: got %b expected 0", ScoreErr);
    end
    step(1'b1, 6, 16'h0666, 1'b0, 0, 0, 1'b0, 0);
    checks++;
    if (ScoreErr !== m_err || ScoreErr !== 1'b1) begin
      errors++;
      $display("FAIL underflow_err: got %b expected %b", ScoreErr, m_err);
    end
    do_reset();
  endtask

  task automatic test_same_edge();
    logic [W-1:0] e;
    step(1'b0, 0, '0, 1'b0, 0, 0, 1'b1, 1);
    step(1'b1, 1, 16'h5A5A, 1'b0, 0, 0, 1'b1, 1);
    step(1'b0, 0, '0, 1'b1, 1, 1, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || BusyA !== 1'b1 || ScoreErr !== 1'b0) begin
      errors++;
      $display("FAIL issue_write_same_edge: got %h err=%b expected %h err=0",
               {BusyA, BusyB, ReadDataA, ReadDataB}, ScoreErr, e);
    end
    step(1'b1, 1, 16'h1111, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 1, 0, 1'b0, 0);
    pop_exp(e);
    checks++;
    if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || BusyA !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_drain: got %h expected %h", {BusyA, BusyB, ReadDataA, ReadDataB}, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic re;
      re = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7), WORD_W'($urandom_range(0, 65535)),
           re, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      if (re) pop_exp(e);
      else e = last_exp;
      checks++;
      if ({BusyA, BusyB, ReadDataA, ReadDataB} !== e || obs_stall !== exp_stall || ScoreErr !== m_err) begin
        errors++;
        $display("FAIL random_%0d: got %h stall=%b err=%b expected %h stall=%b err=%b", i,
                 {BusyA, BusyB, ReadDataA, ReadDataB}, obs_stall, ScoreErr, e, exp_stall, m_err);
      end
      if ($urandom_range(0, 60) == 0) do_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    RegWriteEnable = 1'b0; RegWriteAddr = '0; RegWriteData = '0;
    ReadEnable = 1'b0; ReadAddrA = '0; ReadAddrB = '0;
    IssueEnable = 1'b0; IssueAddr = '0;
    last_exp = '0;
    m_err = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_stall();
    test_overflow();
    test_same_edge();
    test_back_to_back();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
